// File: rtl/noc_switch_pkg.sv
// Shared types and round-robin helper for the route reservation arbiter.
// The top honours ROUTE_ARB_FAST_RELEASE_EN (same-edge re-grant on relieve).
package noc_switch_pkg;

  localparam int unsigned DEF_PORTS = 5;
  localparam int unsigned DEF_REQ_W = 3;
  localparam int unsigned SEL_W     = DEF_REQ_W;
  localparam int unsigned RR_MAX    = 1 << SEL_W;

  typedef enum logic {
    ST_FREE   = 1'b0,
    ST_LOCKED = 1'b1
  } out_state_e;

  // Scans from last+1 upward (mod n); the lowest offset hit wins.
  function automatic logic [SEL_W-1:0] rr_next(
    input logic [RR_MAX-1:0] mask,
    input logic [SEL_W-1:0]  last,
    input int unsigned       n = DEF_PORTS
  );
    logic [SEL_W-1:0] win;
    logic [SEL_W-1:0] idx;
    win = last;
    for (int unsigned k = RR_MAX; k >= 1; k--) begin
      idx = SEL_W'((32'(last) + k) % n);
      if (k <= n && mask[idx]) win = idx;
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick over one output's candidate mask.
// The ROUTE_ARB_FAST_RELEASE_EN option lives in the top only.
module rr_arbiter
  import noc_switch_pkg::*;
#(
  parameter int unsigned PORTS = DEF_PORTS
) (
  input  logic [PORTS-1:0] req_i,
  input  logic [SEL_W-1:0] last_i,
  output logic [PORTS-1:0] gnt_o,
  output logic [SEL_W-1:0] idx_o,
  output logic             valid_o
);

  logic [RR_MAX-1:0] mask;

  always_comb begin
    mask             = '0;
    mask[PORTS-1:0]  = req_i;
    idx_o            = rr_next(mask, last_i, PORTS);
    valid_o          = |req_i;
    gnt_o            = '0;
    if (valid_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/route_reserve_arbiter.sv
// Per-output round-robin lock allocator between head-flit buffers and crossbar.
// Define ROUTE_ARB_FAST_RELEASE_EN to let a relieved output re-grant on the same edge.
module route_reserve_arbiter
  import noc_switch_pkg::*;
#(
  parameter int unsigned PORTS         = DEF_PORTS,
  parameter int unsigned REQUEST_WIDTH = DEF_REQ_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PORTS-1:0]           routeReserveRequestValid,
  input  logic [PORTS*REQUEST_WIDTH-1:0] routeReserveRequest,
  input  logic [PORTS-1:0]           routeRelieve,
  output logic [PORTS-1:0]           routeReserveStatus_Switch,
  output logic [PORTS-1:0]           outputBusy,
  output logic [PORTS*REQUEST_WIDTH-1:0] outputSelect,
  output logic                       requestError
);

  out_state_e [PORTS-1:0] state_q, state_d;
  logic [PORTS-1:0][SEL_W-1:0] sel_q, sel_d;
  logic [PORTS-1:0][SEL_W-1:0] last_q, last_d;
  logic [PORTS-1:0] gnt_q, gnt_d;
  logic             err_q, err_d;

  logic [PORTS-1:0]             owned;
  logic [PORTS-1:0][PORTS-1:0]  cand;
  logic [PORTS-1:0][PORTS-1:0]  win_gnt;
  logic [PORTS-1:0][SEL_W-1:0]  win_idx;
  logic [PORTS-1:0]             win_v;

  // An input already holding any output may not bid for another.
  always_comb begin
    owned = '0;
    for (int o = 0; o < PORTS; o++) begin
      for (int i = 0; i < PORTS; i++) begin
        if (state_q[o] == ST_LOCKED && sel_q[o] == SEL_W'(i))
          owned[i] = 1'b1;
      end
    end
  end

  always_comb begin
    cand  = '0;
    err_d = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (routeReserveRequestValid[i]) begin
        if (32'(routeReserveRequest[i*REQUEST_WIDTH +: REQUEST_WIDTH]) >= PORTS)
          err_d = 1'b1;
        for (int o = 0; o < PORTS; o++) begin
          if (routeReserveRequest[i*REQUEST_WIDTH +: REQUEST_WIDTH]
              == REQUEST_WIDTH'(o) && !owned[i])
            cand[o][i] = 1'b1;
        end
      end
    end
  end

  for (genvar o = 0; o < PORTS; o++) begin : g_arb
    rr_arbiter #(
      .PORTS (PORTS)
    ) u_arb (
      .req_i   (cand[o]),
      .last_i  (last_q[o]),
      .gnt_o   (win_gnt[o]),
      .idx_o   (win_idx[o]),
      .valid_o (win_v[o])
    );
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    gnt_d   = '0;
    for (int o = 0; o < PORTS; o++) begin
      unique case (state_q[o])
        ST_FREE: begin
          if (win_v[o]) begin
            state_d[o] = ST_LOCKED;
            sel_d[o]   = win_idx[o];
            last_d[o]  = win_idx[o];
            gnt_d      = gnt_d | win_gnt[o];
          end
        end
        ST_LOCKED: begin
          if (routeRelieve[sel_q[o]]) begin
            state_d[o] = ST_FREE;
            sel_d[o]   = '0;
`ifdef ROUTE_ARB_FAST_RELEASE_EN
            if (win_v[o]) begin
              state_d[o] = ST_LOCKED;
              sel_d[o]   = win_idx[o];
              last_d[o]  = win_idx[o];
              gnt_d      = gnt_d | win_gnt[o];
            end
`endif
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < PORTS; o++) begin
        state_q[o] <= ST_FREE;
        sel_q[o]   <= '0;
        last_q[o]  <= SEL_W'(PORTS - 1);
      end
      gnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    outputSelect = '0;
    for (int o = 0; o < PORTS; o++) begin
      outputBusy[o] = (state_q[o] == ST_LOCKED);
      outputSelect[o*REQUEST_WIDTH +: REQUEST_WIDTH] = REQUEST_WIDTH'(sel_q[o]);
    end
  end

  assign routeReserveStatus_Switch = gnt_q;
  assign requestError              = err_q;

endmodule

// File: tb/tb_route_reserve_arbiter.sv
// Bench for route_reserve_arbiter: vector table, corner sequences, random vs model.
// Honours ROUTE_ARB_FAST_RELEASE_EN for release latency expectations.
module tb_route_reserve_arbiter;

  localparam int P = 5;
  localparam int W = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [P-1:0]   v   = '0;
  logic [P*W-1:0] rq  = '0;
  logic [P-1:0]   rl  = '0;
  logic [P-1:0]   gnt;
  logic [P-1:0]   busy;
  logic [P*W-1:0] sel;
  logic           err;

  int total = 0;
  int bad   = 0;

  route_reserve_arbiter dut (
    .clk                       (clk),
    .rst                       (rst),
    .routeReserveRequestValid  (v),
    .routeReserveRequest       (rq),
    .routeRelieve              (rl),
    .routeReserveStatus_Switch (gnt),
    .outputBusy                (busy),
    .outputSelect              (sel),
    .requestError              (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [P-1:0]   v;
    logic [P*W-1:0] rq;
    logic [P-1:0]   rl;
    logic [P-1:0]   gnt;
    logic [P-1:0]   busy;
    logic [P*W-1:0] sel;
    logic           err;
  } vec_t;

  vec_t tbl[10];

  int m_owner[P];
  int m_last[P];

  function automatic vec_t mk(
    logic [P-1:0] v_, logic [P*W-1:0] rq_, logic [P-1:0] rl_,
    logic [P-1:0] g_, logic [P-1:0] b_, logic [P*W-1:0] s_, logic e_);
    vec_t r;
    r.v = v_; r.rq = rq_; r.rl = rl_;
    r.gnt = g_; r.busy = b_; r.sel = s_; r.err = e_;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference: owners as ints (-1 = free), rotating search by arithmetic.
  task automatic model_step(
    input  logic [P-1:0]   v_, input logic [P*W-1:0] rq_,
    input  logic [P-1:0]   rl_,
    output logic [P-1:0]   eg, output logic [P-1:0] eb,
    output logic [P*W-1:0] es, output logic ee);
    int  nown[P];
    bit  owns[P];
    bit  can;
    int  i;
    int  t;
    eg = '0; eb = '0; es = '0; ee = 1'b0;
    for (int k = 0; k < P; k++) owns[k] = 0;
    for (int o = 0; o < P; o++)
      if (m_owner[o] >= 0) owns[m_owner[o]] = 1;
    for (int o = 0; o < P; o++) begin
      nown[o] = m_owner[o];
      if (nown[o] >= 0 && rl_[nown[o]]) nown[o] = -1;
    end
    for (int o = 0; o < P; o++) begin
`ifdef ROUTE_ARB_FAST_RELEASE_EN
      can = (nown[o] < 0);
`else
      can = (m_owner[o] < 0);
`endif
      if (can) begin
        for (int k = 1; k <= P; k++) begin
          i = (m_last[o] + k) % P;
          t = int'(rq_[i*W +: W]);
          if (v_[i] && t == o && !owns[i]) begin
            nown[o] = i; m_last[o] = i; eg[i] = 1'b1;
            break;
          end
        end
      end
    end
    for (int k = 0; k < P; k++)
      if (v_[k] && int'(rq_[k*W +: W]) >= P) ee = 1'b1;
    for (int o = 0; o < P; o++) begin
      m_owner[o] = nown[o];
      eb[o] = (nown[o] >= 0);
      if (nown[o] >= 0) es[o*W +: W] = W'(nown[o]);
    end
  endtask

  task automatic relieve_wait(input int owner, input int winner, input logic [P-1:0] keep);
    int n;
    rl = '0; rl[owner] = 1'b1;
    step;
    rl = '0;
    n = 0;
    while (gnt == '0 && n < 6) begin
      step;
      n++;
    end
    check($sformatf("cont_gnt_%0d", winner), 32'(gnt), 32'(1 << winner));
    check($sformatf("cont_sel_%0d", winner), 32'(sel[5:3]), 32'(winner));
`ifdef ROUTE_ARB_FAST_RELEASE_EN
    check($sformatf("cont_lat_%0d", winner), 32'(n), 32'd0);
`else
    check($sformatf("cont_lat_%0d", winner), 32'(n), 32'd1);
`endif
    v = keep;
  endtask

  initial begin
    logic [P-1:0]   eg, eb;
    logic [P*W-1:0] es;
    logic           ee;

    tbl[0] = mk('0, '0, '0, '0, '0, '0, 1'b0);
    tbl[1] = mk(5'b00100, 15'h0100, '0, 5'b00100, 5'b10000, 15'h2000, 1'b0);
    tbl[2] = mk(5'b00100, 15'h0100, '0, '0, 5'b10000, 15'h2000, 1'b0);
    tbl[3] = mk('0, '0, 5'b01000, '0, 5'b10000, 15'h2000, 1'b0);
    tbl[4] = mk('0, '0, 5'b00100, '0, '0, '0, 1'b0);
    tbl[5] = mk(5'b00010, 15'h0030, '0, '0, '0, '0, 1'b1);
    tbl[6] = mk(5'b00010, 15'h0030, '0, '0, '0, '0, 1'b1);
    tbl[7] = mk(5'b00011, 15'h001A, '0, 5'b00011, 5'b01100, 15'h0200, 1'b0);
    tbl[8] = mk('0, '0, '0, '0, 5'b01100, 15'h0200, 1'b0);
    tbl[9] = mk('0, '0, 5'b00011, '0, '0, '0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_sel", 32'(sel), 0);
    check("rst_err", 32'(err), 0);
    rst = 1'b1;

    for (int r = 0; r < 10; r++) begin
      v = tbl[r].v; rq = tbl[r].rq; rl = tbl[r].rl;
      step;
      check($sformatf("row%0d_gnt", r), 32'(gnt), 32'(tbl[r].gnt));
      check($sformatf("row%0d_busy", r), 32'(busy), 32'(tbl[r].busy));
      check($sformatf("row%0d_sel", r), 32'(sel), 32'(tbl[r].sel));
      check($sformatf("row%0d_err", r), 32'(err), 32'(tbl[r].err));
    end
    v = '0; rq = '0; rl = '0;

    // Contention on output 1 from inputs 0, 1, 3.
    v = 5'b01011; rq = 15'h0209;
    step;
    check("cont_first", 32'(gnt), 32'b00001);
    check("cont_busy", 32'(busy), 32'b00010);
    v = 5'b01010;
    step;
    check("cont_wait", 32'(gnt), 0);
    rl = 5'b01000;
    step;
    rl = '0;
    check("nonowner_busy", 32'(busy), 32'b00010);
    check("nonowner_sel", 32'(sel[5:3]), 0);
    check("nonowner_gnt", 32'(gnt), 0);
    relieve_wait(0, 1, 5'b01000);
    relieve_wait(1, 3, 5'b00000);
    rl = 5'b01000;
    step;
    rl = '0;
    step;
    check("cont_free", 32'(busy), 0);

    // Reset in the middle of three locks.
    v = 5'b00111; rq = 15'h0088;
    step;
    check("lock3_gnt", 32'(gnt), 32'b00111);
    check("lock3_busy", 32'(busy), 32'b00111);
    v = '0;
    #2 rst = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_gnt", 32'(gnt), 0);
    check("midrst_sel", 32'(sel), 0);
    step;
    rst = 1'b1;
    v = 5'b10001; rq = 15'h2002;
    step;
    check("postrst_gnt", 32'(gnt), 32'b00001);
    check("postrst_sel", 32'(sel[8:6]), 0);
    v = '0; rq = '0;

    // Random stimulus against the reference model.
    rst = 1'b0;
    step;
    rst = 1'b1;
    for (int o = 0; o < P; o++) begin
      m_owner[o] = -1;
      m_last[o]  = P - 1;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < P; i++) begin
        v[i]        = ($urandom_range(0, 1) == 1);
        rq[i*W +: W] = W'($urandom_range(0, 7));
        rl[i]       = ($urandom_range(0, 3) == 0);
      end
      model_step(v, rq, rl, eg, eb, es, ee);
      step;
      check($sformatf("rnd%0d_gnt", c), 32'(gnt), 32'(eg));
      check($sformatf("rnd%0d_busy", c), 32'(busy), 32'(eb));
      check($sformatf("rnd%0d_sel", c), 32'(sel), 32'(es));
      check($sformatf("rnd%0d_err", c), 32'(err), 32'(ee));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/route_reserve_arbiter.md
# route_reserve_arbiter

Switch-side allocator that consumes route reservation requests from every input port's head-flit buffer and returns the per-port reservation status. For each output port it runs a round-robin arbiter. It locks the winning input to that output until the owner signals relieve, and drives the crossbar select and busy flags. It sits between the per-port head-flit buffers and the crossbar of one router.

## Interface
- `PORTS`, 5, number of router input ports; also the number of output ports.
- `REQUEST_WIDTH`, 3, width of one route request, which is the output port index; must satisfy 2^REQUEST_WIDTH >= PORTS.
- `clk` input 1, sole clock, rising edge.
- `rst` input 1, asynchronous active-low reset; logic is in reset while 0.
- `routeReserveRequestValid` input PORTS, bit i means input i is requesting the output in its request slice.
- `routeReserveRequest` input PORTS*REQUEST_WIDTH, slice i is the target output index for input i.
- `routeRelieve` input PORTS, bit i means input i releases the output it owns (tail flit sent).
- `routeReserveStatus_Switch` output PORTS, one-cycle grant pulse to input i.
- `outputBusy` output PORTS, bit o means output o is currently owned.
- `outputSelect` output PORTS*REQUEST_WIDTH, slice o is the owning input index of output o; 0 when free.
- `requestError` output 1, one-cycle pulse for any valid request with index >= PORTS.

## Operation
- Each output o has a two-state FSM, Free and Locked(owner).
- **Free → Locked**
  - Candidates are inputs i with a valid request, target o, and no output already owned by i.
  - The round-robin winner starts searching at `(lastOwner[o]+1) mod PORTS`.
  - On the winning edge:
    - the FSM becomes Locked;
    - `outputSelect[o]` is set to the winner;
    - `lastOwner[o]` is updated to the winner;
    - `routeReserveStatus_Switch[winner]` pulses for exactly one cycle.
- **Locked → Free**
  - Takes `routeRelieve[owner]` sampled high.
  - `routeRelieve` from a non-owner is ignored.
- An input that is still requesting after its grant pulse gets no second pulse, because it already owns an output.
- Requests with index >= PORTS:
  - are never granted;
  - pulse `requestError` the next cycle;
  - do not affect arbitration.
- Several outputs may grant in the same cycle, each to a different input.

## Timing
- **Reset** values while `rst`=0:
  - all outputs Free;
  - `outputBusy` = 0, `outputSelect` = 0;
  - `routeReserveStatus_Switch` = 0, `requestError` = 0;
  - `lastOwner` = PORTS-1, so input 0 has first priority.
- Reset is asynchronous and may be asserted mid-lock: all locks drop immediately and no grant pulse is emitted.
- **Grant latency:** request valid at edge t gives `routeReserveStatus_Switch` high during cycle t+1 and low at t+2. All grant and status outputs are registered.
- **Busy timing:** `outputBusy`/`outputSelect` become valid in the same cycle as the grant pulse.
- **Release:**
  - `routeRelieve` sampled at edge t makes the output Free after t.
  - Earliest new grant pulse is cycle t+2 without the Configuration feature.
- **Simultaneous events:**
  - Relieve and competing requests on the same output in the same cycle: the new grant is deferred one cycle, unless the Configuration feature is enabled.
  - A request arriving while its output is Locked waits indefinitely; fairness is guaranteed by the rotating priority.

## Configuration
- Macro: `ROUTE_ARB_FAST_RELEASE_EN`.
- **Defined:**
  - a Locked output whose owner relieves at edge t may re-grant at that same edge;
  - the previous owner is excluded from the candidates;
  - the new grant pulse appears in cycle t+1.
- **Undefined:** the output passes through Free for at least one cycle.

## Structure
- Package `noc_switch_pkg`:
  - `SEL_W` = REQUEST_WIDTH;
  - typedef of the output FSM state enum (Free, Locked);
  - function `rr_next(mask, last)` returning the winning index.
- Sub-module `rr_arbiter` (PORTS request mask and last pointer in, one-hot grant plus index out, combinational). Instantiated once per output inside a generate loop.
- The owner-busy mask per input is derived from all `outputBusy`/`outputSelect` in the top module.

## Test plan
- **Single request:** after reset, input 2 requests output 4 → `routeReserveStatus_Switch` = 5'b00100 for one cycle; `outputBusy` = 5'b10000; `outputSelect[4]` = 2.
- **Contention:** inputs 0, 1 and 3 request output 1 at once. Grants go to 0, then 1, then 3, each after the previous owner pulses `routeRelieve`. The new grant is two cycles after each relieve with the macro off and one cycle after with it on.
- **Non-owner relieve:** input 3 pulses `routeRelieve` while output 1 is owned by input 0 → lock unchanged; no grant.
- **Invalid index:** input 1 requests index 6 with PORTS=5 → `requestError` pulses once per cycle valid; no grant; `outputBusy` stays 0.
- **Reset mid-lock:** three outputs locked and `rst` driven 0 mid-cycle → all outputs reset immediately; first grant after release goes to input 0.
- **Parallel grants:** inputs 0→2 and 1→3 request in the same cycle → both grant pulses in the same cycle.
